i2s_slave_rx: RTL and testbench

I2S slave receiver, the receive-side counterpart of the team's I2S master codec.
- Accepts externally driven SCK, WS and SD from an I2S transmitter, which may be the codec itself.
- Oversamples these inputs on wb_clk and deserializes left/right words MSB-first.
- Writes each word into the shared sample buffer, using the same address counter and half-buffer event scheme as the transmit path.

---
 rtl/i2s_slave_rx.sv | 147 ++++++++++++++
 tb/tb_i2s_slave_rx.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_slave_rx.sv
// rtl/i2s_slave_rx.sv - I2S slave receiver writing deserialized words into the shared sample buffer
module i2s_slave_rx #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 15,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  wb_clk,
    input  logic                  wb_rst,
    input  logic                  conf_en,
    input  logic [5:0]            conf_res,
    input  logic                  conf_swap,
    input  logic                  i2s_sck_i,
    input  logic                  i2s_ws_i,
    input  logic                  i2s_sd_i,
    output logic [DATA_WIDTH-1:0] sample_dat_o,
    output logic [ADDR_WIDTH-2:0] sample_addr,
    output logic                  mem_wr,
    output logic                  evt_lsbf,
    output logic                  evt_hsbf,
    output logic                  rx_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        WRITE = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-2:0] ADDR_LSBF = {1'b0, {(ADDR_WIDTH-2){1'b1}}};
    localparam logic [ADDR_WIDTH-2:0] ADDR_HSBF = {(ADDR_WIDTH-1){1'b1}};
    localparam logic [ADDR_WIDTH-2:0] ADDR_ONE  = {{(ADDR_WIDTH-2){1'b0}}, 1'b1};

    state_t                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0]  ws_sync_q, ws_sync_d;
    logic [SYNC_STAGES-1:0]  sd_sync_q, sd_sync_d;
    logic                    sck_prev_q, sck_prev_d;
    logic                    ws_prev_q, ws_prev_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [5:0]              bit_cnt_q, bit_cnt_d;
    logic [ADDR_WIDTH-2:0]   addr_q, addr_d;

    logic                    sck_s, ws_s, sd_s;
    logic                    sck_rise, ws_chg;
    logic [5:0]              res_eff;
    logic [DATA_WIDTH-1:0]   sd_vec;

    // WS and SD come from the same stage as SCK so all three are seen coherently
    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign ws_s     = ws_sync_q[SYNC_STAGES-1];
    assign sd_s     = sd_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev_q;
    assign ws_chg   = sck_rise & (ws_s != ws_prev_q);
    assign res_eff  = (conf_res >= 6'd16 && conf_res <= 6'd32) ? conf_res : 6'd16;

    // Registers; a low enable behaves exactly like reset, synchronizers included
    always_ff @(posedge wb_clk) begin
        if (wb_rst || !conf_en) begin
            state_q    <= IDLE;
            sck_sync_q <= '0;
            ws_sync_q  <= '0;
            sd_sync_q  <= '0;
            sck_prev_q <= 1'b0;
            ws_prev_q  <= 1'b0;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            sck_sync_q <= sck_sync_d;
            ws_sync_q  <= ws_sync_d;
            sd_sync_q  <= sd_sync_d;
            sck_prev_q <= sck_prev_d;
            ws_prev_q  <= ws_prev_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            addr_q     <= addr_d;
        end
    end

    // Synchronizer shifting, word-select tracking and the receive state machine
    always_comb begin
        sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], i2s_sck_i};
        ws_sync_d  = {ws_sync_q[SYNC_STAGES-2:0], i2s_ws_i};
        sd_sync_d  = {sd_sync_q[SYNC_STAGES-2:0], i2s_sd_i};
        sck_prev_d = sck_s;
        ws_prev_d  = ws_prev_q;
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        addr_d     = addr_q;
        sd_vec     = '0;
        sd_vec[0]  = sd_s;

        if (sck_rise) begin
            ws_prev_d = ws_s;
        end

        case (state_q)
            IDLE: begin
                // The bit on the sync edge is the tail of an unsynced word: drop it
                if (ws_chg && (ws_s == conf_swap)) begin
                    shift_d   = '0;
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (sck_rise) begin
                    if (32'(bit_cnt_q) < DATA_WIDTH) begin
                        shift_d = shift_q | (sd_vec << (DATA_WIDTH - 1 - 32'(bit_cnt_q)));
                    end
                    bit_cnt_d = (bit_cnt_q == 6'd63) ? 6'd63 : bit_cnt_q + 6'd1;
                    // One-bit delay: the edge carrying the WS change also carries the LSB
                    if (ws_chg) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                addr_d    = addr_q + ADDR_ONE;
                shift_d   = '0;
                bit_cnt_d = '0;
                state_d   = SHIFT;
            end
            default: state_d = IDLE;
        endcase
    end

    // Buffer write port and event pulses, all active only during the WRITE cycle
    always_comb begin
        sample_dat_o = '0;
        sample_addr  = addr_q;
        mem_wr       = 1'b0;
        evt_lsbf     = 1'b0;
        evt_hsbf     = 1'b0;
        rx_err       = 1'b0;
        if (state_q == WRITE) begin
            sample_dat_o = shift_q;
            mem_wr       = 1'b1;
            evt_lsbf     = (addr_q == ADDR_LSBF);
            evt_hsbf     = (addr_q == ADDR_HSBF);
            rx_err       = (bit_cnt_q != res_eff);
        end
    end

endmodule

// File: tb/tb_i2s_slave_rx.sv
// tb/tb_i2s_slave_rx.sv - self-checking bench for i2s_slave_rx
module tb_i2s_slave_rx;

    localparam int DW = 16;
    localparam int AW = 4;

    logic          wb_clk = 1'b0;
    logic          wb_rst;
    logic          conf_en;
    logic [5:0]    conf_res;
    logic          conf_swap;
    logic          i2s_sck_i;
    logic          i2s_ws_i;
    logic          i2s_sd_i;
    logic [DW-1:0] sample_dat_o;
    logic [AW-2:0] sample_addr;
    logic          mem_wr;
    logic          evt_lsbf;
    logic          evt_hsbf;
    logic          rx_err;

    i2s_slave_rx #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SYNC_STAGES(2)) dut (
        .wb_clk       (wb_clk),
        .wb_rst       (wb_rst),
        .conf_en      (conf_en),
        .conf_res     (conf_res),
        .conf_swap    (conf_swap),
        .i2s_sck_i    (i2s_sck_i),
        .i2s_ws_i     (i2s_ws_i),
        .i2s_sd_i     (i2s_sd_i),
        .sample_dat_o (sample_dat_o),
        .sample_addr  (sample_addr),
        .mem_wr       (mem_wr),
        .evt_lsbf     (evt_lsbf),
        .evt_hsbf     (evt_hsbf),
        .rx_err       (rx_err)
    );

    always #5 wb_clk = ~wb_clk;

    typedef struct {
        logic [5:0]    res;
        int            nbits;
        logic [63:0]   data;
        logic [DW-1:0] exp_dat;
        logic          exp_err;
    } vec_t;

    typedef struct {
        logic [DW-1:0] dat;
        logic [AW-2:0] addr;
        logic          err;
        logic          lsbf;
        logic          hsbf;
    } exp_t;

    exp_t          exp_q[$];
    vec_t          vecs[10];
    int            n_vec = 0;
    int            n_err = 0;
    logic [AW-2:0] exp_addr = '0;
    logic          prev_wr = 1'b0;
    exp_t          got;

    task automatic wait_clk(input int n);
        repeat (n) @(negedge wb_clk);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [DW-1:0] dat, input logic err);
        exp_t e;
        e.dat  = dat;
        e.addr = exp_addr;
        e.err  = err;
        e.lsbf = (exp_addr == 3'd3);
        e.hsbf = (exp_addr == 3'd7);
        exp_q.push_back(e);
        exp_addr = exp_addr + 3'd1;
    endtask

    task automatic slot(input logic ws, input logic sd);
        @(negedge wb_clk);
        i2s_ws_i = ws;
        i2s_sd_i = sd;
        wait_clk(4);
        i2s_sck_i = 1'b1;
        wait_clk(6);
        i2s_sck_i = 1'b0;
    endtask

    // bits hi..lo of data, WS flips on bit 0 (LSB) as I2S demands
    task automatic send_bits(input logic [63:0] data, input int hi, input int lo, input logic ws_w);
        for (int i = hi; i >= lo; i--) begin
            slot((i == 0) ? ~ws_w : ws_w, (i < 64) ? data[i] : 1'b0);
        end
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 200 && exp_q.size() != 0; k++) wait_clk(1);
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_mem_wr"}, 64'(mem_wr), 64'd0);
        check({tag, "_dat"},    64'(sample_dat_o), 64'd0);
        check({tag, "_addr"},   64'(sample_addr), 64'd0);
        check({tag, "_evt"},    64'({evt_lsbf, evt_hsbf, rx_err}), 64'd0);
    endtask

    // Scoreboard: every write strobe pops one expectation; outside writes everything stays 0
    always @(negedge wb_clk) begin
        if (!wb_rst) begin
            if (mem_wr) begin
                if (prev_wr) begin
                    n_err++;
                    $display("FAIL wr_pulse_width: mem_wr high two cycles, expected one");
                end
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_write: dat=%h addr=%0d, expected no write", sample_dat_o, sample_addr);
                end else begin
                    got = exp_q.pop_front();
                    if (sample_dat_o !== got.dat || sample_addr !== got.addr || rx_err !== got.err ||
                        evt_lsbf !== got.lsbf || evt_hsbf !== got.hsbf) begin
                        n_err++;
                        $display("FAIL write: got dat=%h addr=%0d err=%b lsbf=%b hsbf=%b expected dat=%h addr=%0d err=%b lsbf=%b hsbf=%b",
                                 sample_dat_o, sample_addr, rx_err, evt_lsbf, evt_hsbf,
                                 got.dat, got.addr, got.err, got.lsbf, got.hsbf);
                    end
                end
            end else if (sample_dat_o !== '0 || evt_lsbf || evt_hsbf || rx_err) begin
                n_err++;
                $display("FAIL idle_outputs: dat=%h lsbf=%b hsbf=%b err=%b, expected all 0",
                         sample_dat_o, evt_lsbf, evt_hsbf, rx_err);
            end
            prev_wr = mem_wr;
        end
    end

    initial begin
        vecs[0] = '{6'd16, 16, 64'hA5C3,                 16'hA5C3, 1'b0};
        vecs[1] = '{6'd16, 16, 64'h1234,                 16'h1234, 1'b0};
        vecs[2] = '{6'd24, 24, 64'hABCDEF,               16'hABCD, 1'b0};
        vecs[3] = '{6'd24, 24, 64'h123456,               16'h1234, 1'b0};
        vecs[4] = '{6'd16, 12, 64'hF0F,                  16'hF0F0, 1'b1};
        vecs[5] = '{6'd16, 16, 64'h5A5A,                 16'h5A5A, 1'b0};
        vecs[6] = '{6'd16, 66, 64'hFFFF_0000_0000_0000,  16'h3FFF, 1'b1};
        vecs[7] = '{6'd16, 16, 64'h0001,                 16'h0001, 1'b0};
        vecs[8] = '{6'd20, 16, 64'h8000,                 16'h8000, 1'b1};
        vecs[9] = '{6'd40, 16, 64'hFFFF,                 16'hFFFF, 1'b0};

        wb_rst    = 1'b1;
        conf_en   = 1'b0;
        conf_res  = 6'd16;
        conf_swap = 1'b0;
        i2s_sck_i = 1'b0;
        i2s_ws_i  = 1'b1;
        i2s_sd_i  = 1'b0;
        wait_clk(5);
        check_quiet("reset");
        wb_rst  = 1'b0;
        conf_en = 1'b1;
        wait_clk(3);

        // swap=0: WS high preamble, then the 1->0 sync edge carrying a 1 that must be dropped
        for (int i = 0; i < 3; i++) slot(1'b1, 1'b1);
        slot(1'b0, 1'b1);
        for (int v = 0; v < 10; v++) begin
            conf_res = vecs[v].res;
            push_exp(vecs[v].exp_dat, vecs[v].exp_err);
            send_bits(vecs[v].data, vecs[v].nbits - 1, 0, v[0]);
        end
        drain("drain_table");

        // swap=1: data under WS=0 before the 0->1 edge is ignored
        conf_en = 1'b0;
        wait_clk(3);
        check_quiet("dis1");
        conf_swap = 1'b1;
        conf_res  = 6'd16;
        exp_addr  = '0;
        conf_en   = 1'b1;
        wait_clk(2);
        for (int i = 0; i < 6; i++) slot(1'b0, 1'b1);
        slot(1'b1, 1'b1);
        push_exp(16'hC0DE, 1'b0);
        send_bits(64'hC0DE, 15, 0, 1'b1);
        push_exp(16'hBEEF, 1'b0);
        send_bits(64'hBEEF, 15, 0, 1'b0);
        drain("drain_swap");

        // enable dropped after 7 bits: partial word lost, resync from IDLE at address 0
        conf_en = 1'b0;
        wait_clk(3);
        conf_swap = 1'b0;
        exp_addr  = '0;
        conf_en   = 1'b1;
        wait_clk(2);
        slot(1'b1, 1'b0);
        slot(1'b0, 1'b1);
        send_bits(64'h1357, 15, 9, 1'b0);
        conf_en = 1'b0;
        wait_clk(4);
        check_quiet("dis2");
        conf_en = 1'b1;
        wait_clk(2);
        send_bits(64'h1357, 8, 0, 1'b0);
        send_bits(64'h9999, 15, 0, 1'b1);
        push_exp(16'h7E81, 1'b0);
        send_bits(64'h7E81, 15, 0, 1'b0);
        push_exp(16'h2468, 1'b0);
        send_bits(64'h2468, 15, 0, 1'b1);
        drain("drain_reenable");

        // stopped SCK: nothing further may be written
        wait_clk(50);
        check("idle_stopped_sck", 64'(mem_wr), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
